// File: rtl/flip_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flip_pipe                                                       |
// | Purpose  : Two-stage valid/ready pipeline that reorders a WIDTH-bit word   |
// |            (pass / bit reverse / group swap / in-group reverse) and counts |
// |            completed output transfers.                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module flip_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_mode,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int c_ngroup = WIDTH / GROUP;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [1:0]       r_s1_mode;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_mode;
    logic [CNT_W-1:0] r_cnt;

    logic             w_adv2;
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_gswap;
    logic [WIDTH-1:0] w_grev;
    logic [WIDTH-1:0] w_flip;

    assign w_adv2   = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_adv2;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    // Reorder networks are pure wiring off the S1 register.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_rev[i] = r_s1_data[WIDTH-1-i];
    end

    for (genvar g = 0; g < c_ngroup; g++) begin : g_grp
        for (genvar j = 0; j < GROUP; j++) begin : g_gbit
            assign w_gswap[g*GROUP+j] = r_s1_data[(c_ngroup-1-g)*GROUP+j];
            assign w_grev[g*GROUP+j]  = r_s1_data[g*GROUP+GROUP-1-j];
        end
    end

    always_comb begin
        w_flip = r_s1_data;
        case (r_s1_mode)
            2'b00:   w_flip = r_s1_data;
            2'b01:   w_flip = w_rev;
            2'b10:   w_flip = w_gswap;
            2'b11:   w_flip = w_grev;
            default: w_flip = r_s1_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 2'b00;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
            r_s1_mode  <= in_mode;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Output register only moves when empty or being drained, so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mode  <= 2'b00;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            r_out_data  <= w_flip;
            r_out_mode  <= r_s1_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_mode  = r_out_mode;
    assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flip_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_flip_pipe                                                    |
// | Purpose  : Self-checking bench for flip_pipe (32/8/16 and 16/4/4 builds).  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_flip_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=32, GROUP=8, CNT_W=16
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_cnt_clr = 1'b0;
    logic [31:0] a_in_data = '0, a_out_data;
    logic [1:0]  a_in_mode = '0, a_out_mode;
    logic [15:0] a_xfer_cnt;

    // Instance B: WIDTH=16, GROUP=4, CNT_W=4
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_cnt_clr = 1'b0;
    logic [15:0] b_in_data = '0, b_out_data;
    logic [1:0]  b_in_mode = '0, b_out_mode;
    logic [3:0]  b_xfer_cnt;

    flip_pipe #(.WIDTH(32), .GROUP(8), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode),
        .cnt_clr(a_cnt_clr), .xfer_cnt(a_xfer_cnt)
    );

    flip_pipe #(.WIDTH(16), .GROUP(4), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
        .cnt_clr(b_cnt_clr), .xfer_cnt(b_xfer_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] qa[$];
    logic [17:0] qb[$];
    logic [15:0] cnt_a = '0;
    logic [3:0]  cnt_b = '0;
    int          n_xfer_a = 0;
    logic        a_acc = 1'b0, b_acc = 1'b0;
    logic        a_stall = 1'b0, b_stall = 1'b0;
    logic [33:0] a_hold = '0;
    logic [17:0] b_hold = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit reversal done numerically: peel LSBs off v and push them into r.
    function automatic logic [63:0] rev_bits(input logic [63:0] v, input int n);
        logic [63:0] r = '0;
        logic [63:0] x = v;
        repeat (n) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_flip(input logic [63:0] d, input logic [1:0] m,
                                             input int w, input int gs);
        logic [63:0] r    = '0;
        int          ng   = w / gs;
        logic [63:0] gmod = 64'd1 << gs;
        case (m)
            2'd0: r = d;
            2'd1: r = rev_bits(d, w);
            2'd2: for (int g = 0; g < ng; g++)
                      r += ((d >> (g * gs)) % gmod) << ((ng - 1 - g) * gs);
            default: for (int g = 0; g < ng; g++)
                      r += rev_bits((d >> (g * gs)) % gmod, gs) << (g * gs);
        endcase
        return r;
    endfunction

    // One clock: observe at the falling edge, update models, return 1 time unit after the rising edge.
    task automatic cyc();
        logic [33:0] ea;
        logic [17:0] eb;
        @(negedge clk);
        chk("a_in_ready", 64'(a_in_ready), 64'(!(qa.size() == 2 && !a_out_ready)));
        chk("a_xfer_cnt", 64'(a_xfer_cnt), 64'(cnt_a));
        if (qa.size() == 0) chk("a_idle_valid", 64'(a_out_valid), 64'd0);
        if (a_stall) chk("a_hold", 64'({a_out_valid, a_out_mode, a_out_data}), 64'({1'b1, a_hold}));
        a_stall = a_out_valid && !a_out_ready;
        a_hold  = {a_out_mode, a_out_data};
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected", 64'(a_out_valid), 64'd0);
            else begin
                ea = qa.pop_front();
                chk("a_data", 64'({a_out_mode, a_out_data}), 64'(ea));
            end
            n_xfer_a++;
        end
        cnt_a = a_cnt_clr ? 16'd0 : cnt_a + 16'(a_out_valid && a_out_ready);
        a_acc = a_in_valid && a_in_ready;
        if (a_acc) qa.push_back({a_in_mode, 32'(ref_flip(64'(a_in_data), a_in_mode, 32, 8))});

        chk("b_in_ready", 64'(b_in_ready), 64'(!(qb.size() == 2 && !b_out_ready)));
        chk("b_xfer_cnt", 64'(b_xfer_cnt), 64'(cnt_b));
        if (qb.size() == 0) chk("b_idle_valid", 64'(b_out_valid), 64'd0);
        if (b_stall) chk("b_hold", 64'({b_out_valid, b_out_mode, b_out_data}), 64'({1'b1, b_hold}));
        b_stall = b_out_valid && !b_out_ready;
        b_hold  = {b_out_mode, b_out_data};
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected", 64'(b_out_valid), 64'd0);
            else begin
                eb = qb.pop_front();
                chk("b_data", 64'({b_out_mode, b_out_data}), 64'(eb));
            end
        end
        cnt_b = b_cnt_clr ? 4'd0 : cnt_b + 4'(b_out_valid && b_out_ready);
        b_acc = b_in_valid && b_in_ready;
        if (b_acc) qb.push_back({b_in_mode, 16'(ref_flip(64'(b_in_data), b_in_mode, 16, 4))});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp1 [4];
        logic [15:0] exp6 [3];
        logic [1:0]  mode6 [3];
        int          w;
        exp1[0] = 32'h12345678; exp1[1] = 32'h1E6A2C48;
        exp1[2] = 32'h78563412; exp1[3] = 32'h482C6A1E;
        exp6[0] = 16'h3C5A; exp6[1] = 16'h5A3C; exp6[2] = 16'hC3A5;
        mode6[0] = 2'd2; mode6[1] = 2'd3; mode6[2] = 2'd1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data",  64'({a_out_mode, a_out_data}), 64'd0);
        chk("rst_xfer_cnt",  64'(a_xfer_cnt), 64'd0);
        chk("rst_in_ready",  64'(a_in_ready), 64'd1);

        // Test 1: four back-to-back words, one per mode
        a_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_in_valid = (k < 4);
            a_in_data  = 32'h12345678;
            a_in_mode  = 2'(k);
            cyc();
            if (k == 0) chk("t1_latency", 64'(a_out_valid), 64'd0);
            else if (k <= 4) begin
                chk("t1_valid", 64'(a_out_valid), 64'd1);
                chk("t1_word", 64'(a_out_data), 64'(exp1[k-1]));
            end
        end
        a_in_valid = 1'b0;
        repeat (3) cyc();

        // Test 2: 8 random words with a 5-cycle consumer stall mid-stream
        w = 0;
        a_in_valid = 1'b1;
        a_in_data  = $urandom;
        a_in_mode  = 2'($urandom_range(0, 3));
        for (int k = 0; k < 30; k++) begin
            a_out_ready = !(k >= 4 && k < 9);
            a_in_valid  = (w < 8);
            cyc();
            if (k == 8) chk("t2_full_in_ready", 64'(a_in_ready), 64'd0);
            if (a_acc) begin
                w++;
                a_in_data = $urandom;
                a_in_mode = 2'($urandom_range(0, 3));
            end
        end
        chk("t2_pending", 64'(qa.size()), 64'd0);

        // Test 3: out_ready toggles every cycle with continuous input
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        a_cnt_clr = 1'b1;
        cyc();
        a_cnt_clr = 1'b0;
        n_xfer_a = 0;
        a_in_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            a_out_ready = k[0];
            cyc();
            if (a_acc) begin
                a_in_data = $urandom;
                a_in_mode = 2'($urandom_range(0, 3));
            end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) cyc();
        chk("t3_cnt_vs_xfers", 64'(a_xfer_cnt), 64'(n_xfer_a));
        chk("t3_pending", 64'(qa.size()), 64'd0);

        // Test 6: WIDTH=16 GROUP=4 fixed vectors
        b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_in_valid = (k < 3);
            b_in_data  = 16'hA5C3;
            b_in_mode  = mode6[k % 3];
            cyc();
            if (k >= 1) chk("t6_word", 64'(b_out_data), 64'(exp6[k-1]));
        end
        b_in_valid = 1'b0;
        repeat (2) cyc();

        // Test 4: CNT_W=4 wrap and clear priority
        b_cnt_clr = 1'b1;
        cyc();
        b_cnt_clr = 1'b0;
        b_in_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            b_in_data = 16'($urandom);
            b_in_mode = 2'($urandom_range(0, 3));
            cyc();
        end
        b_in_valid = 1'b0;
        repeat (3) cyc();
        chk("t4_cnt_max", 64'(b_xfer_cnt), 64'hF);
        b_in_valid = 1'b1;
        b_in_data = 16'($urandom);
        cyc();
        b_in_valid = 1'b0;
        repeat (3) cyc();
        chk("t4_cnt_wrap", 64'(b_xfer_cnt), 64'd0);
        b_in_valid = 1'b1;
        b_in_data = 16'h1234;
        cyc();
        b_in_data = 16'h5678;
        cyc();
        b_in_valid = 1'b0;
        cyc();
        chk("t4_cnt_pre_clr", 64'(b_xfer_cnt), 64'd1);
        chk("t4_valid_pre_clr", 64'(b_out_valid), 64'd1);
        b_cnt_clr = 1'b1;
        cyc();
        b_cnt_clr = 1'b0;
        chk("t4_clr_priority", 64'(b_xfer_cnt), 64'd0);
        repeat (2) cyc();

        // Test 5: asynchronous reset with both stages full
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = $urandom;
        repeat (4) begin
            cyc();
            if (a_acc) a_in_data = $urandom;
        end
        chk("t5_full", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(a_out_valid), 64'd0);
        chk("t5_rst_data",  64'(a_out_data), 64'd0);
        chk("t5_rst_cnt",   64'(a_xfer_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        qa.delete(); qb.delete();
        cnt_a = '0; cnt_b = '0;
        a_stall = 1'b0; b_stall = 1'b0;
        a_out_ready = 1'b1;
        #1;
        chk("t5_in_ready", 64'(a_in_ready), 64'd1);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
